proc_fetch_unit: RTL and testbench

- Fetch stage (F) of the TinyRV1 five-stage pipeline, directly upstream of the pipeline control/decode logic.
- Owns the PC and issues pipelined instruction-memory requests over a val/rdy interface.
- Buffers in-order responses together with their PCs and hands them to D under stall control.
- Applies redirects from control (JR/JAL/taken-BNE) and discards wrong-path responses that are still in flight.

---
 rtl/proc_fetch_unit.sv | 146 ++++++++++++++
 tb/tb_proc_fetch_unit.sv | 442 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/proc_fetch_unit.sv
// TinyRV1 fetch stage: PC, pipelined imem requests, in-order response buffer.
// Optional perf counters via PROC_FETCH_PERF_EN.
`timescale 1ns/1ps
module proc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h00000200,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  c2d_pc_sel_F,
  input  logic        c2d_reg_en_F,
  input  logic [31:0] jr_target,
  input  logic [31:0] jal_target,
  input  logic [31:0] br_target,
  output logic        imemreq_val,
  input  logic        imemreq_rdy,
  output logic [31:0] imemreq_addr,
  input  logic        imemresp_val,
  input  logic [31:0] imemresp_data,
  output logic        f2d_val,
  output logic [31:0] f2d_inst,
  output logic [31:0] f2d_pc,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_drop_cnt
);
  localparam int PW = (DEPTH > 2) ? 2 : 1;
  localparam int CW = 3;
  localparam logic [CW-1:0] DEP  = CW'(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] infl_q, infl_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] tw_q, tw_d, tr_q, tr_d;
  logic [PW-1:0] bw_q, bw_d, br_q, br_d;
  logic [31:0]   tag_q  [DEPTH];
  logic [31:0]   inst_q [DEPTH];
  logic [31:0]   bpc_q  [DEPTH];
  logic redirect, fire, resp, pop;
  logic drop_now, push;

  function automatic logic [PW-1:0] inc(
    input logic [PW-1:0] p
  );
    inc = (p == LAST) ? '0 : p + PW'(1);
  endfunction

  assign redirect     = |c2d_pc_sel_F;
  assign imemreq_val  = rst & ~redirect &
                        ((infl_q + cnt_q) < DEP);
  assign imemreq_addr = pc_q;
  assign fire         = imemreq_val & imemreq_rdy;
  // Stray responses with nothing tracked are ignored
  assign resp         = imemresp_val & (infl_q != '0);
  assign drop_now     = resp &
                        (redirect | (drop_q != '0));
  assign push         = resp & ~drop_now;
  assign f2d_val      = (cnt_q != '0);
  assign pop          = f2d_val & c2d_reg_en_F;
  assign f2d_inst     = f2d_val ? inst_q[br_q] : '0;
  assign f2d_pc       = f2d_val ? bpc_q[br_q] : '0;

  always_comb begin
    pc_d = pc_q;
    unique case (c2d_pc_sel_F)
      2'd1:    pc_d = jr_target;
      2'd2:    pc_d = jal_target;
      2'd3:    pc_d = br_target;
      default: pc_d = fire ? pc_q + 32'd4 : pc_q;
    endcase
  end

  always_comb begin
    infl_d = infl_q + CW'(fire) - CW'(resp);
    drop_d = drop_q;
    if (redirect)
      drop_d = infl_q - CW'(resp);
    else if (resp && (drop_q != '0))
      drop_d = drop_q - CW'(1);
    tw_d = fire ? inc(tw_q) : tw_q;
    tr_d = resp ? inc(tr_q) : tr_q;
  end

  always_comb begin
    cnt_d = '0;
    bw_d  = '0;
    br_d  = '0;
    if (!redirect) begin
      cnt_d = cnt_q + CW'(push) - CW'(pop);
      bw_d  = push ? inc(bw_q) : bw_q;
      br_d  = pop ? inc(br_q) : br_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q   <= RESET_PC;
      infl_q <= '0;
      drop_q <= '0;
      cnt_q  <= '0;
      tw_q   <= '0;
      tr_q   <= '0;
      bw_q   <= '0;
      br_q   <= '0;
    end else begin
      pc_q   <= pc_d;
      infl_q <= infl_d;
      drop_q <= drop_d;
      cnt_q  <= cnt_d;
      tw_q   <= tw_d;
      tr_q   <= tr_d;
      bw_q   <= bw_d;
      br_q   <= br_d;
    end
  end

  always_ff @(posedge clk) begin
    if (fire)
      tag_q[tw_q] <= pc_q;
    if (push) begin
      inst_q[bw_q] <= imemresp_data;
      bpc_q[bw_q]  <= tag_q[tr_q];
    end
  end

`ifdef PROC_FETCH_PERF_EN
  logic [31:0] pf_q, pd_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pf_q <= '0;
      pd_q <= '0;
    end else begin
      pf_q <= pf_q + 32'(pop);
      pd_q <= pd_q + 32'(drop_now);
    end
  end

  assign perf_fetch_cnt = pf_q;
  assign perf_drop_cnt  = pd_q;
`else
  assign perf_fetch_cnt = '0;
  assign perf_drop_cnt  = '0;
`endif
endmodule

// File: tb/tb_proc_fetch_unit.sv
// Bench for proc_fetch_unit: queue-level reference model plus
// in-order imem model with random latency.
`timescale 1ns/1ps
module tb_proc_fetch_unit;
  localparam int DEPTH = 2;
  localparam logic [31:0] RPC = 32'h200;
`ifdef PROC_FETCH_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic [1:0] sel;
  logic reg_en, rdy;
  logic [31:0] jr_t, jal_t, br_t;
  logic req_val;
  logic [31:0] req_addr;
  logic resp_val;
  logic [31:0] resp_data;
  logic f_val;
  logic [31:0] f_inst, f_pc, pf, pd;

  always #5 clk = ~clk;

  proc_fetch_unit #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .c2d_pc_sel_F(sel), .c2d_reg_en_F(reg_en),
    .jr_target(jr_t), .jal_target(jal_t),
    .br_target(br_t),
    .imemreq_val(req_val), .imemreq_rdy(rdy),
    .imemreq_addr(req_addr),
    .imemresp_val(resp_val),
    .imemresp_data(resp_data),
    .f2d_val(f_val), .f2d_inst(f_inst), .f2d_pc(f_pc),
    .perf_fetch_cnt(pf), .perf_drop_cnt(pd)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic        drop;
  } tag_t;
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } ent_t;
  typedef struct {
    logic [31:0] addr;
    int unsigned due;
  } mreq_t;

  tag_t  m_infl[$];
  ent_t  m_buf[$];
  mreq_t mem_q[$];
  logic [31:0] m_pc;
  int m_fetch, m_drop;
  int unsigned cyc = 0;
  int unsigned lat_min = 1, lat_max = 1;
  int checks = 0, failures = 0;

  logic e_rv, e_fv, resp_now;
  logic [31:0] e_ra, e_fi, e_fp, e_pf, e_pd;

  function automatic logic [31:0] memword(
    input logic [31:0] a
  );
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
  endfunction

  task automatic do_reset();
    rst = 1'b0; sel = 2'd0; reg_en = 1'b1; rdy = 1'b1;
    jr_t = 0; jal_t = 0; br_t = 0;
    resp_val = 1'b0; resp_data = 0;
    m_infl.delete(); m_buf.delete(); mem_q.delete();
    m_pc = RPC; m_fetch = 0; m_drop = 0;
    @(posedge clk); @(posedge clk);
    #1 rst = 1'b1;
  endtask

  // Present memory response, then derive expectations from the model
  task automatic prep();
    resp_now = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
    resp_val = resp_now;
    resp_data = resp_now ? memword(mem_q[0].addr) : $urandom;
    #1;
    e_rv = (sel == 2'd0) &&
           (m_infl.size() + m_buf.size() < DEPTH);
    e_ra = m_pc;
    e_fv = m_buf.size() > 0;
    e_fi = e_fv ? m_buf[0].inst : 32'h0;
    e_fp = e_fv ? m_buf[0].pc : 32'h0;
    e_pf = PERF ? 32'(m_fetch) : 32'h0;
    e_pd = PERF ? 32'(m_drop) : 32'h0;
  endtask

  task automatic adv();
    logic [1:0] s;
    logic en, fm, fd;
    logic [31:0] a;
    tag_t t;
    s = sel; en = reg_en;
    fm = e_rv && rdy;
    fd = req_val && rdy;
    a = req_addr;
    @(posedge clk); #1;
    cyc++;
    if (resp_now) void'(mem_q.pop_front());
    if (fd)
      mem_q.push_back('{a,
        cyc - 1 + $urandom_range(lat_max, lat_min)});
    if (m_buf.size() > 0 && en) begin
      void'(m_buf.pop_front());
      m_fetch++;
    end
    if (resp_now && m_infl.size() > 0) begin
      t = m_infl.pop_front();
      if (s != 2'd0 || t.drop) m_drop++;
      else m_buf.push_back({memword(t.pc), t.pc});
    end
    if (s != 2'd0) begin
      m_buf.delete();
      foreach (m_infl[k]) m_infl[k].drop = 1'b1;
      m_pc = (s == 2'd1) ? jr_t :
             (s == 2'd2) ? jal_t : br_t;
    end else if (fm) begin
      m_infl.push_back({m_pc, 1'b0});
      m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; sel = 2'd0; reg_en = 1'b1; rdy = 1'b1;
    resp_val = 1'b0; resp_data = 0;
    jr_t = 0; jal_t = 0; br_t = 0;
    #2;
    checks += 6;
    if (req_val !== 1'b0) begin failures++;
      $display("FAIL rst_req_val got=%b exp=0", req_val); end
    if (f_val !== 1'b0) begin failures++;
      $display("FAIL rst_f2d_val got=%b exp=0", f_val); end
    if (f_inst !== 32'h0) begin failures++;
      $display("FAIL rst_f2d_inst got=%h exp=0", f_inst); end
    if (f_pc !== 32'h0) begin failures++;
      $display("FAIL rst_f2d_pc got=%h exp=0", f_pc); end
    if (pf !== 32'h0) begin failures++;
      $display("FAIL rst_perf_fetch got=%h exp=0", pf); end
    if (pd !== 32'h0) begin failures++;
      $display("FAIL rst_perf_drop got=%h exp=0", pd); end
    do_reset();
    prep();
    checks += 2;
    if (req_val !== 1'b1) begin failures++;
      $display("FAIL rst_first_val got=%b exp=1", req_val); end
    if (req_addr !== RPC) begin failures++;
      $display("FAIL rst_first_addr got=%h exp=%h",
               req_addr, RPC); end
  endtask

  task automatic test_stream();
    logic [31:0] fa[$], dp[$];
    do_reset(); lat_min = 1; lat_max = 1;
    for (int i = 0; i < 12; i++) begin
      prep();
      checks += 2;
      if (req_val !== e_rv) begin failures++;
        $display("FAIL str_req_val c=%0d got=%b exp=%b",
                 i, req_val, e_rv); end
      if (f_pc !== e_fp) begin failures++;
        $display("FAIL str_f2d_pc c=%0d got=%h exp=%h",
                 i, f_pc, e_fp); end
      if (req_val && rdy) fa.push_back(req_addr);
      if (f_val && reg_en) dp.push_back(f_pc);
      adv();
    end
    checks++;
    if (fa.size() < 3 || dp.size() < 3) begin failures++;
      $display("FAIL str_count got=%0d/%0d exp>=3/3",
               fa.size(), dp.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks += 2;
        if (fa[k] !== RPC + 32'(4 * k)) begin failures++;
          $display("FAIL str_addr k=%0d got=%h exp=%h",
                   k, fa[k], RPC + 32'(4 * k)); end
        if (dp[k] !== RPC + 32'(4 * k)) begin failures++;
          $display("FAIL str_dpc k=%0d got=%h exp=%h",
                   k, dp[k], RPC + 32'(4 * k)); end
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] dp[$];
    int nf = 0;
    do_reset(); lat_min = 1; lat_max = 1;
    for (int i = 0; i < 6; i++) begin
      reg_en = 1'b0;
      prep();
      if (req_val && rdy) nf++;
      checks++;
      if (req_val !== e_rv) begin failures++;
        $display("FAIL stl_req_val c=%0d got=%b exp=%b",
                 i, req_val, e_rv); end
      if (i >= 3) begin
        checks += 2;
        if (f_val !== 1'b1) begin failures++;
          $display("FAIL stl_f2d_val c=%0d got=%b exp=1",
                   i, f_val); end
        if (f_inst !== memword(RPC)) begin failures++;
          $display("FAIL stl_hold c=%0d got=%h exp=%h",
                   i, f_inst, memword(RPC)); end
      end
      adv();
    end
    checks++;
    if (nf != DEPTH) begin failures++;
      $display("FAIL stl_issued got=%0d exp=%0d", nf, DEPTH); end
    for (int i = 0; i < 12; i++) begin
      reg_en = 1'b1;
      prep();
      checks++;
      if (f_inst !== e_fi) begin failures++;
        $display("FAIL stl_inst c=%0d got=%h exp=%h",
                 i, f_inst, e_fi); end
      if (f_val) dp.push_back(f_pc);
      adv();
    end
    checks++;
    if (dp.size() < 4) begin failures++;
      $display("FAIL stl_count got=%0d exp>=4", dp.size()); end
    foreach (dp[k]) begin
      checks++;
      if (dp[k] !== RPC + 32'(4 * k)) begin failures++;
        $display("FAIL stl_seq k=%0d got=%h exp=%h",
                 k, dp[k], RPC + 32'(4 * k)); end
    end
  endtask

  task automatic test_redirect_jal();
    logic [31:0] fa[$], dp[$];
    do_reset(); lat_min = 3; lat_max = 3;
    jal_t = 32'h300;
    for (int i = 0; i < 14; i++) begin
      sel = (i == 2) ? 2'd2 : 2'd0;
      prep();
      checks += 2;
      if (req_val !== e_rv) begin failures++;
        $display("FAIL jal_req_val c=%0d got=%b exp=%b",
                 i, req_val, e_rv); end
      if (f_pc !== e_fp) begin failures++;
        $display("FAIL jal_f2d_pc c=%0d got=%h exp=%h",
                 i, f_pc, e_fp); end
      if (i > 2 && req_val && rdy) fa.push_back(req_addr);
      if (i > 2 && f_val) dp.push_back(f_pc);
      adv();
    end
    sel = 2'd0;
    checks += 3;
    if (fa.size() == 0 || fa[0] !== 32'h300) begin failures++;
      $display("FAIL jal_addr got=%h exp=300",
               (fa.size() > 0) ? fa[0] : 32'hx); end
    if (dp.size() == 0 || dp[0] !== 32'h300) begin failures++;
      $display("FAIL jal_dpc got=%h exp=300",
               (dp.size() > 0) ? dp[0] : 32'hx); end
    if (pd !== (PERF ? 32'd2 : 32'd0)) begin failures++;
      $display("FAIL jal_perf_drop got=%0d exp=%0d",
               pd, PERF ? 2 : 0); end
  endtask

  task automatic test_redirect_resp();
    logic [31:0] dp[$];
    do_reset(); lat_min = 1; lat_max = 1;
    br_t = 32'h240;
    for (int i = 0; i < 10; i++) begin
      sel = (i == 2) ? 2'd3 : 2'd0;
      prep();
      if (i == 2) begin
        checks += 2;
        if (resp_val !== 1'b1) begin failures++;
          $display("FAIL br_resp_on_redir got=%b exp=1",
                   resp_val); end
        if (f_val !== 1'b1 || f_pc !== RPC) begin failures++;
          $display("FAIL br_redir_head got=%b/%h exp=1/%h",
                   f_val, f_pc, RPC); end
      end
      if (i == 3) begin
        checks += 2;
        if (f_val !== 1'b0) begin failures++;
          $display("FAIL br_flushed got=%b exp=0", f_val); end
        if (req_val !== 1'b1 || req_addr !== 32'h240) begin
          failures++;
          $display("FAIL br_target_req got=%b/%h exp=1/240",
                   req_val, req_addr); end
      end
      checks++;
      if (f_pc !== e_fp) begin failures++;
        $display("FAIL br_f2d_pc c=%0d got=%h exp=%h",
                 i, f_pc, e_fp); end
      if (i > 2 && f_val) dp.push_back(f_pc);
      adv();
    end
    sel = 2'd0;
    checks += 2;
    if (dp.size() == 0 || dp[0] !== 32'h240) begin failures++;
      $display("FAIL br_dpc got=%h exp=240",
               (dp.size() > 0) ? dp[0] : 32'hx); end
    if (pd !== (PERF ? 32'd1 : 32'd0)) begin failures++;
      $display("FAIL br_perf_drop got=%0d exp=%0d",
               pd, PERF ? 1 : 0); end
  endtask

  task automatic test_rdy_toggle();
    logic [31:0] fa[$], dp[$];
    do_reset(); lat_min = 1; lat_max = 1;
    for (int i = 0; i < 20; i++) begin
      rdy = (i % 2 == 0);
      prep();
      checks++;
      if (req_val !== e_rv ||
          (e_rv && req_addr !== e_ra)) begin failures++;
        $display("FAIL rdy_req c=%0d got=%b/%h exp=%b/%h",
                 i, req_val, req_addr, e_rv, e_ra); end
      if (req_val && rdy) fa.push_back(req_addr);
      if (f_val) dp.push_back(f_pc);
      adv();
    end
    rdy = 1'b1;
    checks++;
    if (dp.size() < 3) begin failures++;
      $display("FAIL rdy_count got=%0d exp>=3", dp.size()); end
    foreach (fa[k]) begin
      checks++;
      if (fa[k] !== RPC + 32'(4 * k)) begin failures++;
        $display("FAIL rdy_addr k=%0d got=%h exp=%h",
                 k, fa[k], RPC + 32'(4 * k)); end
    end
    foreach (dp[k]) begin
      checks++;
      if (dp[k] !== RPC + 32'(4 * k)) begin failures++;
        $display("FAIL rdy_dpc k=%0d got=%h exp=%h",
                 k, dp[k], RPC + 32'(4 * k)); end
    end
  endtask

  task automatic test_mid_reset();
    logic [31:0] fa[$], dp[$];
    do_reset(); lat_min = 1; lat_max = 1;
    for (int i = 0; i < 4; i++) begin
      prep(); adv();
    end
    prep();
    #2 rst = 1'b0;
    #1;
    checks += 5;
    if (req_val !== 1'b0) begin failures++;
      $display("FAIL mrst_req_val got=%b exp=0", req_val); end
    if (f_val !== 1'b0) begin failures++;
      $display("FAIL mrst_f2d_val got=%b exp=0", f_val); end
    if (f_pc !== 32'h0 || f_inst !== 32'h0) begin failures++;
      $display("FAIL mrst_f2d got=%h/%h exp=0/0",
               f_pc, f_inst); end
    if (pf !== 32'h0) begin failures++;
      $display("FAIL mrst_perf_fetch got=%0d exp=0", pf); end
    if (pd !== 32'h0) begin failures++;
      $display("FAIL mrst_perf_drop got=%0d exp=0", pd); end
    do_reset();
    for (int i = 0; i < 8; i++) begin
      prep();
      checks++;
      if (f_pc !== e_fp) begin failures++;
        $display("FAIL mrst_f2d_pc c=%0d got=%h exp=%h",
                 i, f_pc, e_fp); end
      if (req_val && rdy) fa.push_back(req_addr);
      if (f_val) dp.push_back(f_pc);
      adv();
    end
    checks += 2;
    if (fa.size() == 0 || fa[0] !== RPC) begin failures++;
      $display("FAIL mrst_addr got=%h exp=%h",
               (fa.size() > 0) ? fa[0] : 32'hx, RPC); end
    if (dp.size() == 0 || dp[0] !== RPC) begin failures++;
      $display("FAIL mrst_dpc got=%h exp=%h",
               (dp.size() > 0) ? dp[0] : 32'hx, RPC); end
  endtask

  task automatic test_random();
    do_reset(); lat_min = 1; lat_max = 3;
    for (int i = 0; i < 600; i++) begin
      sel = ($urandom_range(0, 9) == 0) ?
            2'($urandom_range(1, 3)) : 2'd0;
      reg_en = ($urandom_range(0, 9) < 7);
      rdy = ($urandom_range(0, 3) != 0);
      jr_t = {$urandom, 2'b00} & 32'h0000_0FFC;
      jal_t = {$urandom, 2'b00} & 32'h0000_0FFC;
      br_t = {$urandom, 2'b00} & 32'h0000_0FFC;
      prep();
      checks += 6;
      if (req_val !== e_rv ||
          (e_rv && req_addr !== e_ra)) begin failures++;
        $display("FAIL rnd_req c=%0d got=%b/%h exp=%b/%h",
                 i, req_val, req_addr, e_rv, e_ra); end
      if (f_val !== e_fv) begin failures++;
        $display("FAIL rnd_f2d_val c=%0d got=%b exp=%b",
                 i, f_val, e_fv); end
      if (f_inst !== e_fi) begin failures++;
        $display("FAIL rnd_f2d_inst c=%0d got=%h exp=%h",
                 i, f_inst, e_fi); end
      if (f_pc !== e_fp) begin failures++;
        $display("FAIL rnd_f2d_pc c=%0d got=%h exp=%h",
                 i, f_pc, e_fp); end
      if (pf !== e_pf) begin failures++;
        $display("FAIL rnd_perf_fetch c=%0d got=%0d exp=%0d",
                 i, pf, e_pf); end
      if (pd !== e_pd) begin failures++;
        $display("FAIL rnd_perf_drop c=%0d got=%0d exp=%0d",
                 i, pd, e_pd); end
      adv();
    end
    sel = 2'd0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect_jal();
    test_redirect_resp();
    test_rdy_toggle();
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule
